// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//
// Assembles 4-byte command frames (SOF, ID, VAL, CHK) from the UART
// receiver's ready/clear handshake. A good frame produces a one-cycle
// command strobe and an ACK response byte. A bad frame produces a NAK
// response byte and increments the error counter. A stalled frame is
// abandoned after a per-byte timeout, counted as an error, and gets no
// response byte.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rdy, rxdata           receiver byte-ready level and received byte
//   rdy_clr               one-cycle pulse that clears the receiver's rdy
//   tx_active             transmitter busy
//   tx_dv, tx_byte        response strobe and byte to the transmitter
//   cmd_valid             one-cycle strobe for a good frame
//   cmd_id, cmd_value     command payload, held until the next cmd_valid
//   err_count             saturating count of rejected or aborted frames

module uart_cmd_parser #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 20,
  parameter logic [7:0]  MAX_ID     = 8'h0B,
  parameter logic [7:0]  SOF        = 8'h23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [7:0] rxdata,
  output logic       rdy_clr,
  input  logic       tx_active,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       cmd_valid,
  output logic [7:0] cmd_id,
  output logic [7:0] cmd_value,
  output logic [7:0] err_count
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  // One extra count of headroom so the limit value itself is representable
  // even when TIMEOUT_CYC is an exact power of two.
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;
  localparam logic [7:0] CHK_KEY = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    GET_ID,
    GET_VAL,
    GET_CHK,
    RESP
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      id_q, id_nxt;
  logic [7:0]      val_q, val_nxt;
  logic [7:0]      resp_q, resp_nxt;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic            rdy_clr_nxt;
  logic            tx_dv_nxt;
  logic [7:0]      tx_byte_nxt;
  logic            cmd_valid_nxt;
  logic [7:0]      cmd_id_nxt;
  logic [7:0]      cmd_value_nxt;
  logic [7:0]      err_count_nxt;
  logic            err_inc;
  logic            accept;
  logic            frame_good;

  // Next-state and next-output logic. A byte is only taken when rdy is high
  // and we are not already clearing the previous one; in RESP the byte is
  // left pending in the receiver until the response has been issued.
  // The checksum is judged against rxdata directly so that cmd_valid can
  // appear in the cycle right after the CHK byte is accepted.
  always_comb begin
    state_nxt     = state;
    id_nxt        = id_q;
    val_nxt       = val_q;
    resp_nxt      = resp_q;
    to_nxt        = to_cnt;
    tx_dv_nxt     = 1'b0;
    tx_byte_nxt   = tx_byte;
    cmd_valid_nxt = 1'b0;
    cmd_id_nxt    = cmd_id;
    cmd_value_nxt = cmd_value;
    err_inc       = 1'b0;

    accept      = rdy && !rdy_clr && (state != RESP);
    rdy_clr_nxt = accept;
    frame_good  = (rxdata == (id_q ^ val_q ^ CHK_KEY)) && (id_q <= MAX_ID);

    case (state)
      IDLE: begin
        to_nxt = '0;
        if (accept && (rxdata == SOF)) begin
          state_nxt = GET_ID;
        end
      end

      GET_ID, GET_VAL, GET_CHK: begin
        // An accept in the same cycle as the timeout wins.
        if (accept) begin
          to_nxt = '0;
          case (state)
            GET_ID: begin
              id_nxt    = rxdata;
              state_nxt = GET_VAL;
            end
            GET_VAL: begin
              val_nxt   = rxdata;
              state_nxt = GET_CHK;
            end
            default: begin
              state_nxt = RESP;
              if (frame_good) begin
                cmd_valid_nxt = 1'b1;
                cmd_id_nxt    = id_q;
                cmd_value_nxt = val_q;
                resp_nxt      = ACK;
              end else begin
                resp_nxt = NAK;
                err_inc  = 1'b1;
              end
            end
          endcase
        end else if (to_cnt == TO_LIMIT) begin
          to_nxt    = '0;
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end

      RESP: begin
        to_nxt = '0;
        if (!tx_active) begin
          tx_dv_nxt   = 1'b1;
          tx_byte_nxt = resp_q;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        to_nxt    = '0;
      end
    endcase

    if (err_inc && (err_count != 8'hFF)) begin
      err_count_nxt = err_count + 8'd1;
    end else begin
      err_count_nxt = err_count;
    end
  end

  // State and output registers. Every output is registered, so a reset
  // clears them immediately and drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      id_q      <= 8'h00;
      val_q     <= 8'h00;
      resp_q    <= 8'h00;
      to_cnt    <= '0;
      rdy_clr   <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_id    <= 8'h00;
      cmd_value <= 8'h00;
      err_count <= 8'h00;
    end else begin
      state     <= state_nxt;
      id_q      <= id_nxt;
      val_q     <= val_nxt;
      resp_q    <= resp_nxt;
      to_cnt    <= to_nxt;
      rdy_clr   <= rdy_clr_nxt;
      tx_dv     <= tx_dv_nxt;
      tx_byte   <= tx_byte_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_id    <= cmd_id_nxt;
      cmd_value <= cmd_value_nxt;
      err_count <= err_count_nxt;
    end
  end

endmodule
